// File: rtl/datagram_transmitter_pkg.sv
// Shared link constants and types for the inter-board datagram link.
// The receiver imports the same package so both ends agree on framing.
package datagram_transmitter_pkg;

    localparam int          DGT_CLK_FREQ    = 100_000_000;
    localparam int          DGT_BAUD        = 115200;
    localparam int          DGT_MESSAGE_SIZE = 16;
    localparam logic [7:0]  DGT_HEADER_BYTE = 8'hA5;
    localparam int          DGT_GAP_BITS    = 2;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int calc_nbytes(input int bits);
        return (bits + 7) / 8;
    endfunction

    localparam int DGT_CLKS_PER_BIT = calc_clks_per_bit(DGT_CLK_FREQ, DGT_BAUD);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        GAP
    } tx_state_t;

endpackage

// File: rtl/datagram_transmitter_if.sv
// Valid/ready datagram handoff into the transmitter.
interface datagram_transmitter_if
    import datagram_transmitter_pkg::*;
#(
    parameter int MESSAGE_SIZE = DGT_MESSAGE_SIZE
);
    logic [MESSAGE_SIZE-1:0] datagram;
    logic                    send_valid;
    logic                    send_ready;

    modport master (output datagram, output send_valid, input send_ready);
    modport slave  (input datagram, input send_valid, output send_ready);
endinterface

// File: rtl/datagram_transmitter_uart_tx_byte.sv
// 8N1 byte serialiser. The shifter idles at all-ones so its LSB is the line.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baud_q, baud_d;
    logic [3:0]       bit_q, bit_d;
    logic [9:0]       sh_q, sh_d;
    logic             active_q, active_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q   <= '0;
            bit_q    <= '0;
            sh_q     <= '1;
            active_q <= 1'b0;
        end else begin
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        baud_d   = baud_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        active_d = active_q;
        // A start in the stop bit's last cycle chains bytes with no idle gap.
        if (start) begin
            baud_d   = '0;
            bit_d    = '0;
            sh_d     = {1'b1, data, 1'b0};
            active_d = 1'b1;
        end else if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                sh_d   = {1'b1, sh_q[9:1]};
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    bit_d    = '0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    assign tx   = sh_q[0];
    assign done = active_q && (baud_q == BAUD_LAST) && (bit_q == 4'd9);

endmodule

// File: rtl/datagram_transmitter.sv
// Frames one datagram as header byte + payload bytes (MSB first) over 8N1,
// followed by an idle-high gap before the next datagram is accepted.
module datagram_transmitter
    import datagram_transmitter_pkg::*;
#(
    parameter int         CLK_FREQ     = DGT_CLK_FREQ,
    parameter int         BAUD         = DGT_BAUD,
    parameter int         MESSAGE_SIZE = DGT_MESSAGE_SIZE,
    parameter logic [7:0] HEADER_BYTE  = DGT_HEADER_BYTE,
    parameter int         GAP_BITS     = DGT_GAP_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    datagram_transmitter_if.slave  tx_if,
    output logic                   TxD,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int NBYTES       = calc_nbytes(MESSAGE_SIZE);
    localparam int SH_W         = NBYTES * 8;
    localparam int IDX_W        = $clog2(NBYTES + 1);
    localparam int GAP_CYC      = GAP_BITS * CLKS_PER_BIT;
    localparam int GAP_W        = $clog2(GAP_CYC + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    tx_state_t        state_q, state_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic       accept;
    logic       byte_start;
    logic [7:0] byte_data;
    logic       byte_done;

    assign accept = tx_if.send_valid && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        byte_start = 1'b0;
        byte_data  = sh_q[SH_W-1 -: 8];
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d                    = '0;
                    sh_d[MESSAGE_SIZE-1:0]  = tx_if.datagram;
                    byte_start              = 1'b1;
                    byte_data               = HEADER_BYTE;
                    idx_d                   = '0;
                    gap_d                   = '0;
                    state_d                 = HEADER;
                end
            end
            HEADER: begin
                // Top byte goes out now; shifting keeps the next one at the top.
                if (byte_done) begin
                    byte_start = 1'b1;
                    sh_d       = sh_q << 8;
                    idx_d      = '0;
                    state_d    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (byte_done) begin
                    if (idx_q == IDX_LAST) begin
                        gap_d   = '0;
                        state_d = GAP;
                    end else begin
                        byte_start = 1'b1;
                        sh_d       = sh_q << 8;
                        idx_d      = idx_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk   (clk),
        .rst   (rst),
        .start (byte_start),
        .data  (byte_data),
        .tx    (TxD),
        .done  (byte_done)
    );

    assign tx_if.send_ready = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign frame_done       = (state_q == GAP) && (gap_q == GAP_LAST);

endmodule
